// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: state encoding and default width shared by the counter sequencer slice.
package counter_seq_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: control/status bundle for counter_sequencer; COUNTER_SEQ_DOWN_EN adds dir.
interface counter_sequencer_if #(parameter int WIDTH = counter_seq_pkg::DEFAULT_WIDTH);
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrapped;
`ifdef COUNTER_SEQ_DOWN_EN
    logic             dir;
    modport master (output start, pause, abort, start_val, end_val, dir,
                    input count, busy, done, wrapped);
    modport slave  (input start, pause, abort, start_val, end_val, dir,
                    output count, busy, done, wrapped);
`else
    modport master (output start, pause, abort, start_val, end_val,
                    input count, busy, done, wrapped);
    modport slave  (input start, pause, abort, start_val, end_val,
                    output count, busy, done, wrapped);
`endif
endinterface

// File: rtl/seq_count_core.sv
// seq_count_core: loadable modulo-2^WIDTH up/down counter with a wrap strobe for the current step.
module seq_count_core #(parameter int WIDTH = 4) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    assign wrap = en && (dir ? count == '0 : count == '1);
    always_ff @(posedge clock or negedge reset)
        if (!reset)     count <= '0;
        else if (clear) count <= '0;
        else if (load)  count <= load_val;
        else if (en)    count <= dir ? count - 1'b1 : count + 1'b1;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: runs one count window start_val..end_val per start request.
// COUNTER_SEQ_DOWN_EN adds a dir input captured with start (1 = count down).
module counter_sequencer
    import counter_seq_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
    input logic                clock,
    input logic                reset,
    counter_sequencer_if.slave bus
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] start_reg, end_reg, count;
    logic             load, en, wrap, capture, done, wrapped, dir_reg;
    assign capture = state == IDLE && bus.start && !bus.abort;
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        en       = 1'b0;
        if (bus.abort) state_nx = IDLE;
        else case (state)
            IDLE:    if (bus.start) state_nx = LOAD;
            LOAD:    begin load = 1'b1; state_nx = RUN; end
            // releasing pause takes the normal RUN step on the same edge
            RUN, PAUSED: begin
                if (bus.pause)            state_nx = PAUSED;
                else if (count == end_reg) state_nx = DONE;
                else begin en = 1'b1; state_nx = RUN; end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            start_reg <= '0;
            end_reg   <= '0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state_nx == DONE;
            if (load)      wrapped <= 1'b0;
            else if (wrap) wrapped <= 1'b1;
            if (capture) begin
                start_reg <= bus.start_val;
                end_reg   <= bus.end_val;
            end
        end
`ifdef COUNTER_SEQ_DOWN_EN
    always_ff @(posedge clock or negedge reset)
        if (!reset)       dir_reg <= 1'b0;
        else if (capture) dir_reg <= bus.dir;
`else
    assign dir_reg = 1'b0;
`endif
    seq_count_core #(.WIDTH(WIDTH)) u_core (
        .clock    (clock),
        .reset    (reset),
        .clear    (bus.abort),
        .load     (load),
        .en       (en),
        .dir      (dir_reg),
        .load_val (start_reg),
        .count    (count),
        .wrap     (wrap)
    );
    assign bus.count   = count;
    assign bus.busy    = state == LOAD || state == RUN || state == PAUSED;
    assign bus.done    = done;
    assign bus.wrapped = wrapped;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed vectors with hand-computed expectations for counter_sequencer.
module tb_counter_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    counter_sequencer_if #(.WIDTH(4)) bus ();
    counter_sequencer #(.WIDTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_window(input logic [3:0] sv, input logic [3:0] ev);
        bus.start     = 1'b1;
        bus.start_val = sv;
        bus.end_val   = ev;
        tick();
        bus.start     = 1'b0;
        bus.start_val = 4'd0;
        bus.end_val   = 4'd0;
    endtask

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
        bus.start_val = 4'd0; bus.end_val = 4'd0;
`ifdef COUNTER_SEQ_DOWN_EN
        bus.dir = 1'b0;
`endif
        #2;
        check("rst_count", bus.count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_wrapped", bus.wrapped, 0);
        tick();
        #2 reset = 1'b1;
        tick();
        check("idle_busy", bus.busy, 0);

        // window 3..7
        begin_window(4'd3, 4'd7);
        check("load_busy", bus.busy, 1);
        check("load_count_holds", bus.count, 0);
        tick();
        check("first_count", bus.count, 3);
        for (int v = 4; v <= 7; v++) begin
            tick();
            check("up_count", bus.count, v);
            check("up_no_done", bus.done, 0);
        end
        tick();
        check("done_pulse", bus.done, 1);
        check("done_count", bus.count, 7);
        check("done_busy", bus.busy, 0);
        tick();
        check("done_one_cycle", bus.done, 0);
        check("after_busy", bus.busy, 0);
        check("after_count", bus.count, 7);

        // window 14..1 wraps
        begin_window(4'd14, 4'd1);
        tick();
        check("wrap_c14", bus.count, 14);
        check("wrap_w14", bus.wrapped, 0);
        tick();
        check("wrap_c15", bus.count, 15);
        check("wrap_w15", bus.wrapped, 0);
        tick();
        check("wrap_c0", bus.count, 0);
        check("wrap_w0", bus.wrapped, 1);
        tick();
        check("wrap_c1", bus.count, 1);
        tick();
        check("wrap_done", bus.done, 1);
        check("wrap_sticky", bus.wrapped, 1);
        tick();

        // window 5..10 with pause at 7
        begin_window(4'd5, 4'd10);
        check("wrap_kept_in_load", bus.wrapped, 1);
        tick();
        check("p_c5", bus.count, 5);
        check("wrap_cleared", bus.wrapped, 0);
        tick();
        tick();
        check("p_c7", bus.count, 7);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_hold", bus.count, 7);
            check("pause_busy", bus.busy, 1);
        end
        bus.pause = 1'b0;
        for (int v = 8; v <= 10; v++) begin
            tick();
            check("p_resume", bus.count, v);
            check("p_no_done", bus.done, 0);
        end
        tick();
        check("p_done", bus.done, 1);
        tick();

        // window 2..12, stray start, abort at 9
        begin_window(4'd2, 4'd12);
        tick();
        check("a_c2", bus.count, 2);
        tick();
        check("a_c3", bus.count, 3);
        bus.start = 1'b1; bus.start_val = 4'd0; bus.end_val = 4'd4;
        tick();
        bus.start = 1'b0;
        check("ign_start_c4", bus.count, 4);
        tick();
        check("ign_start_c5", bus.count, 5);
        check("ign_start_done", bus.done, 0);
        for (int v = 6; v <= 9; v++) tick();
        check("a_c9", bus.count, 9);
        bus.abort = 1'b1;
        bus.pause = 1'b1;
        tick();
        bus.pause = 1'b0;
        check("abort_count", bus.count, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        bus.start = 1'b1; bus.start_val = 4'd6; bus.end_val = 4'd6;
        tick();
        check("abort_start_idle", bus.busy, 0);
        bus.abort = 1'b0; bus.start = 1'b0;
        tick();
        check("abort_no_done", bus.done, 0);
        check("abort_stays_idle", bus.busy, 0);

        // reset mid-run
        begin_window(4'd0, 4'd15);
        tick(); tick(); tick();
        check("r_c2", bus.count, 2);
        #2 reset = 1'b0;
        #1;
        check("areset_count", bus.count, 0);
        check("areset_busy", bus.busy, 0);
        check("areset_done", bus.done, 0);
        tick();
        #2 reset = 1'b1;
        tick();
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_done", bus.done, 0);
        check("post_rst_count", bus.count, 0);
        begin_window(4'd4, 4'd4);
        tick();
        check("k0_c4", bus.count, 4);
        check("k0_no_done", bus.done, 0);
        tick();
        check("k0_done", bus.done, 1);
        check("k0_count", bus.count, 4);
        tick();

`ifdef COUNTER_SEQ_DOWN_EN
        bus.dir = 1'b1;
        begin_window(4'd1, 4'd14);
        bus.dir = 1'b0;
        tick();
        check("dn_c1", bus.count, 1);
        tick();
        check("dn_c0", bus.count, 0);
        check("dn_w0", bus.wrapped, 0);
        tick();
        check("dn_c15", bus.count, 15);
        check("dn_w15", bus.wrapped, 1);
        tick();
        check("dn_c14", bus.count, 14);
        tick();
        check("dn_done", bus.done, 1);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
